// File: rtl/seg7_pkg.sv
// +--------------------------------------------------------------------------+
// | seg7_pkg: segment bit order, digit patterns and encoder FSM state types  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package seg7_pkg;

  // Bus order is {a,b,c,d,e,f,g} = [6:0], 1 = segment lit (common cathode)
  localparam int SEG_BIT_A = 6;
  localparam int SEG_BIT_B = 5;
  localparam int SEG_BIT_C = 4;
  localparam int SEG_BIT_D = 3;
  localparam int SEG_BIT_E = 2;
  localparam int SEG_BIT_F = 1;
  localparam int SEG_BIT_G = 0;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_F     = 7'h47;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } seg_state_t;

  typedef struct packed {
    logic       err;
    logic [3:0] value;
  } seg_code_t;

endpackage

`default_nettype wire

// File: rtl/codificador_7seg_binario_if.sv
// +--------------------------------------------------------------------------+
// | codificador_7seg_binario_if: valid/ready result channel of the encoder   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface codificador_7seg_binario_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_err;

  modport master (output out_valid, output out_data, output out_err, input out_ready);
  modport slave  (input out_valid, input out_data, input out_err, output out_ready);
endinterface

`default_nettype wire

// File: rtl/seg7_lookup.sv
// +--------------------------------------------------------------------------+
// | seg7_lookup: segment pattern -> {err,value}; hex A-F when HEX_DIGITS_EN  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg7_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output seg_code_t  code
);

  always_comb begin
    code = '{err: 1'b1, value: 4'h0};
    case (pattern)
      SEG_0:   code = '{err: 1'b0, value: 4'h0};
      SEG_1:   code = '{err: 1'b0, value: 4'h1};
      SEG_2:   code = '{err: 1'b0, value: 4'h2};
      SEG_3:   code = '{err: 1'b0, value: 4'h3};
      SEG_4:   code = '{err: 1'b0, value: 4'h4};
      SEG_5:   code = '{err: 1'b0, value: 4'h5};
      SEG_6:   code = '{err: 1'b0, value: 4'h6};
      SEG_7:   code = '{err: 1'b0, value: 4'h7};
      SEG_8:   code = '{err: 1'b0, value: 4'h8};
      SEG_9:   code = '{err: 1'b0, value: 4'h9};
`ifdef HEX_DIGITS_EN
      SEG_A:   code = '{err: 1'b0, value: 4'hA};
      SEG_B:   code = '{err: 1'b0, value: 4'hB};
      SEG_C:   code = '{err: 1'b0, value: 4'hC};
      SEG_D:   code = '{err: 1'b0, value: 4'hD};
      SEG_E:   code = '{err: 1'b0, value: 4'hE};
      SEG_F:   code = '{err: 1'b0, value: 4'hF};
`endif
      default: code = '{err: 1'b1, value: 4'h0};
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/codificador_7seg_binario.sv
// +--------------------------------------------------------------------------+
// | codificador_7seg_binario: settle-filtered 7-seg bus -> 4-bit value, once |
// | per new pattern over valid/ready. Option macro: HEX_DIGITS_EN. Rev 1.0   |
// +--------------------------------------------------------------------------+
`default_nettype none

module codificador_7seg_binario
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [6:0]                        seg_in,
  codificador_7seg_binario_if.master        out_if
);

  localparam logic [CNT_W-1:0] STABLE_CNT = STABLE_CYCLES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [6:0]       sync_meta, sync_seg;
  seg_state_t       state, state_nxt;
  logic [6:0]       cand, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [6:0]       last_pat, last_nxt;
  logic             valid, valid_nxt;
  logic [3:0]       data, data_nxt;
  logic             err, err_nxt;
  seg_code_t        code;

  seg7_lookup u_lookup (
    .pattern (cand),
    .code    (code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= SEG_BLANK;
      sync_seg  <= SEG_BLANK;
      state     <= IDLE;
      cand      <= SEG_BLANK;
      cnt       <= '0;
      last_pat  <= SEG_BLANK;
      valid     <= 1'b0;
      data      <= 4'h0;
      err       <= 1'b0;
    end else begin
      sync_meta <= seg_in;
      sync_seg  <= sync_meta;
      state     <= state_nxt;
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      last_pat  <= last_nxt;
      valid     <= valid_nxt;
      data      <= data_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    last_nxt  = last_pat;
    valid_nxt = valid;
    data_nxt  = data;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (sync_seg != last_pat) begin
          cand_nxt  = sync_seg;
          cnt_nxt   = CNT_ONE;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (sync_seg != cand) begin
          cand_nxt = sync_seg;
          cnt_nxt  = CNT_ONE;
        end else if (cnt != STABLE_CNT) begin
          cnt_nxt = cnt + CNT_ONE;
        end else if (cand == last_pat) begin
          // Bus glitched and came back to the already reported pattern
          state_nxt = IDLE;
        end else if (cand == SEG_BLANK) begin
          last_nxt  = SEG_BLANK;
          state_nxt = IDLE;
        end else begin
          last_nxt  = cand;
          valid_nxt = 1'b1;
          data_nxt  = code.value;
          err_nxt   = code.err;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_if.out_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_if.out_valid = valid;
  assign out_if.out_data  = data;
  assign out_if.out_err   = err;

endmodule

`default_nettype wire

// File: tb/tb_codificador_7seg_binario.sv
// +--------------------------------------------------------------------------+
// | tb_codificador_7seg_binario: directed scenarios plus randomized holds    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_codificador_7seg_binario;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = 7'h00;
  logic       dir_ready = 1'b0;
  logic       rnd_ready = 1'b0;
  logic       rand_phase = 1'b0;

  int checks = 0;
  int errors = 0;
  int emit_cnt = 0;
  int exp_cnt = 0;
  int stall = 0;
  logic [4:0] exp_q[$];

  codificador_7seg_binario_if bus ();
  assign bus.out_ready = rand_phase ? rnd_ready : dir_ready;

  codificador_7seg_binario #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seg_in (seg_in),
    .out_if (bus)
  );

  always #5 clk = ~clk;

`ifdef HEX_DIGITS_EN
  localparam int NDIG = 16;
`else
  localparam int NDIG = 10;
`endif

  // Reference table: index is the encoded value
  logic [6:0] digit_pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  function automatic logic [4:0] ref_encode(input logic [6:0] p);
    for (int i = 0; i < NDIG; i++)
      if (digit_pat[i] == p) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.out_valid && cyc < limit);
  endtask

  task automatic count_valid(input int n, output int hits);
    hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.out_valid) hits++;
    end
  endtask

  // Random-phase consumer: random ready, forced after a short stall
  always @(negedge clk) begin
    if (rand_phase) begin
      if (bus.out_valid && stall >= 2) rnd_ready = 1'b1;
      else rnd_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid) begin
        if (rnd_ready) begin
          emit_cnt++;
          stall = 0;
          if (exp_q.size() != 0) begin
            logic [4:0] e;
            e = exp_q.pop_front();
            check("rnd_err", bus.out_err, e[4]);
            check("rnd_data", bus.out_data, e[3:0]);
          end
        end else begin
          stall++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc, hits;
    logic [6:0] last, p;
    logic [4:0] e;

    tick(3);
    check("reset_valid", bus.out_valid, 0);
    check("reset_data", bus.out_data, 0);
    check("reset_err", bus.out_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single emission with exact latency
    seg_in = 7'h6D; dir_ready = 1'b1;
    wait_valid(30, cyc);
    check("t2_latency", cyc, 7);
    check("t2_data", bus.out_data, 2);
    check("t2_err", bus.out_err, 0);
    @(negedge clk);
    check("t2_pulse_len", bus.out_valid, 0);
    count_valid(20, hits);
    check("t2_no_repeat", hits, 0);

    // Short glitch returning to last pattern is ignored
    seg_in = 7'h7E;
    wait_valid(30, cyc);
    check("t3_valid0", bus.out_valid, 1);
    check("t3_data0", bus.out_data, 0);
    @(negedge clk);
    seg_in = 7'h7F; tick(2);
    seg_in = 7'h7E;
    count_valid(20, hits);
    check("t3_glitch", hits, 0);
    seg_in = 7'h7F;
    wait_valid(30, cyc);
    check("t3_valid8", bus.out_valid, 1);
    check("t3_data8", bus.out_data, 8);
    @(negedge clk);

    // Backpressure holds the result; newer pattern picked up after release
    dir_ready = 1'b0; seg_in = 7'h30;
    wait_valid(30, cyc);
    check("t4_data1", bus.out_data, 1);
    seg_in = 7'h79; tick(15);
    check("t4_hold_valid", bus.out_valid, 1);
    check("t4_hold_data", bus.out_data, 1);
    dir_ready = 1'b1;
    @(negedge clk);
    check("t4_accept", bus.out_valid, 0);
    wait_valid(30, cyc);
    check("t4_valid3", bus.out_valid, 1);
    check("t4_data3", bus.out_data, 3);
    @(negedge clk);

    // Illegal and hex patterns
    seg_in = 7'h01;
    wait_valid(30, cyc);
    check("t5_ill_valid", bus.out_valid, 1);
    check("t5_ill_err", bus.out_err, 1);
    check("t5_ill_data", bus.out_data, 0);
    @(negedge clk);
    seg_in = 7'h77;
    wait_valid(30, cyc);
    check("t5_hex_valid", bus.out_valid, 1);
`ifdef HEX_DIGITS_EN
    check("t5_hex_err", bus.out_err, 0);
    check("t5_hex_data", bus.out_data, 4'hA);
`else
    check("t5_hex_err", bus.out_err, 1);
    check("t5_hex_data", bus.out_data, 0);
`endif
    @(negedge clk);

    // Blank in between allows re-emission of the same digit
    seg_in = 7'h5B;
    wait_valid(30, cyc);
    check("t6_data5a", bus.out_data, 5);
    @(negedge clk);
    seg_in = 7'h00;
    count_valid(15, hits);
    check("t6_blank_silent", hits, 0);
    seg_in = 7'h5B;
    wait_valid(30, cyc);
    check("t6_valid5b", bus.out_valid, 1);
    check("t6_data5b", bus.out_data, 5);
    @(negedge clk);

    // Asynchronous reset drops a pending result immediately
    dir_ready = 1'b0; seg_in = 7'h6D;
    wait_valid(30, cyc);
    check("t1_pending", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t1_rst_valid", bus.out_valid, 0);
    check("t1_rst_data", bus.out_data, 0);
    check("t1_rst_err", bus.out_err, 0);
    seg_in = 7'h00;
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // Randomized long holds with optional short glitches between them
    rand_phase = 1'b1;
    last = 7'h00;
    p = 7'h00;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: p = digit_pat[$urandom_range(0, 15)];
        6, 7:             p = 7'($urandom);
        8:                p = 7'h00;
        default:          p = p;
      endcase
      if (p != last) begin
        last = p;
        if (p != 7'h00) begin
          e = ref_encode(p);
          exp_q.push_back(e);
          exp_cnt++;
        end
      end
      seg_in = p;
      tick(20 + $urandom_range(0, 4));
      if (i < 39 && $urandom_range(0, 1) == 1) begin
        seg_in = 7'($urandom);
        tick($urandom_range(1, 2));
      end
    end
    tick(40);
    rand_phase = 1'b0;
    check("rnd_count", emit_cnt, exp_cnt);
    check("rnd_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
